// File: rtl/itag_freelist_pkg.sv
// Shared defaults and helpers for the instruction-tag free list.
// The ROB and writeback stage import the same defaults, so tag widths agree everywhere.
package itag_freelist_pkg;

    // Default tag width; 2**ITAG_TAG_W_DEF tags exist.
    localparam int ITAG_TAG_W_DEF   = 5;
    // Default number of dispatch lanes drawing tags per cycle.
    localparam int ITAG_ALLOC_N_DEF = 4;
    // Default number of writeback ports returning tags per cycle.
    localparam int ITAG_REL_N_DEF   = 8;

    // Number of tags for a given tag width.
    function automatic int itag_depth(input int tag_w);
        return 1 << tag_w;
    endfunction

    // Pointer width: one extra bit distinguishes full from empty.
    function automatic int itag_ptr_w(input int tag_w);
        return tag_w + 1;
    endfunction

endpackage : itag_freelist_pkg

// File: rtl/itag_prefix_cnt.sv
// Exclusive prefix popcounts of a request vector plus its total popcount.
// prefix_o slot i holds the number of set bits strictly below bit i, which is
// the compacted slot offset of lane/port i.
module itag_prefix_cnt #(
    parameter int N  = 4,   // vector width
    parameter int PW = 5,   // prefix field width (prefix never exceeds N-1)
    parameter int CW = 6    // total width (total may reach N)
) (
    input  logic [N-1:0]    vec_i,
    output logic [N*PW-1:0] prefix_o,
    output logic [CW-1:0]   total_o
);

    // Count set bits of v at positions below lim.
    function automatic logic [CW-1:0] count_below(input logic [N-1:0] v, input int lim);
        logic [CW-1:0] c;
        c = '0;
        for (int j = 0; j < N; j++) begin
            if (j < lim) begin
                c = c + CW'(v[j]);
            end
        end
        return c;
    endfunction

    // Each slot gets its own independent count so there is no serial chain.
    for (genvar gi = 0; gi < N; gi++) begin : g_prefix
        assign prefix_o[gi*PW +: PW] = PW'(count_below(vec_i, gi));
    end

    assign total_o = count_below(vec_i, N);

endmodule : itag_prefix_cnt

// File: rtl/itag_freelist.sv
// Instruction-tag free list: a circular buffer of free tags.
// Dispatch lanes pop from the head (compacted, all-or-nothing); writeback ports
// push returned tags at the tail (compacted). Flush and reset restore the
// identity image with every tag free.
module itag_freelist
    import itag_freelist_pkg::*;
#(
    parameter int TAG_W   = ITAG_TAG_W_DEF,
    parameter int ALLOC_N = ITAG_ALLOC_N_DEF,
    parameter int REL_N   = ITAG_REL_N_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [ALLOC_N-1:0]       alloc_req,
    output logic                     alloc_ok,
    output logic [ALLOC_N*TAG_W-1:0] alloc_tag,
    input  logic [REL_N-1:0]         rel_en,
    input  logic [REL_N*TAG_W-1:0]   rel_tag,
    output logic [TAG_W:0]           free_cnt,
    output logic                     ovf_err
);

    localparam int DEPTH = itag_depth(TAG_W);
    localparam int PTR_W = itag_ptr_w(TAG_W);
    localparam int CNT_W = TAG_W + 1;   // counts reach DEPTH
    localparam int SUM_W = TAG_W + 2;   // headroom for free + released

    // Storage and pointers.
    logic [TAG_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic             ovf_err_q;

    // Compaction offsets and batch sizes.
    logic [ALLOC_N*TAG_W-1:0] alloc_pre;
    logic [REL_N*TAG_W-1:0]   rel_pre;
    logic [CNT_W-1:0]         na;
    logic [CNT_W-1:0]         nr;

    // Grant / overflow decision signals.
    logic [PTR_W-1:0] free_now;
    logic [SUM_W-1:0] free_ext, na_ext, nr_ext, take_ext, level_after;
    logic             grant;
    logic             ovf_hit;
    logic             rel_accept;

    // Per-port write slot in the array.
    logic [TAG_W-1:0] rel_idx [REL_N];

    itag_prefix_cnt #(
        .N  (ALLOC_N),
        .PW (TAG_W),
        .CW (CNT_W)
    ) u_alloc_cnt (
        .vec_i    (alloc_req),
        .prefix_o (alloc_pre),
        .total_o  (na)
    );

    itag_prefix_cnt #(
        .N  (REL_N),
        .PW (TAG_W),
        .CW (CNT_W)
    ) u_rel_cnt (
        .vec_i    (rel_en),
        .prefix_o (rel_pre),
        .total_o  (nr)
    );

    // Occupancy is the modular pointer distance.
    assign free_now = wr_ptr_q - rd_ptr_q;

    // Widened operands so free + released never truncates before the compare.
    assign free_ext = SUM_W'(free_now);
    assign na_ext   = SUM_W'(na);
    assign nr_ext   = SUM_W'(nr);

    // Whole group is granted or nothing is; flush kills the grant. Released
    // tags are not bypassed: only the pre-release count is visible.
    assign grant    = (na != '0) && (na_ext <= free_ext) && !flush;
    assign take_ext = grant ? na_ext : '0;

    // A release batch that would push the count past DEPTH means a duplicate
    // or bogus tag came back; drop the whole batch rather than corrupt the list.
    assign level_after = free_ext + nr_ext - take_ext;
    assign ovf_hit     = (level_after > SUM_W'(DEPTH));
    assign rel_accept  = !flush && !ovf_hit && (nr != '0);

    // Lane i reads the head offset by the number of requesting lanes below it.
    for (genvar gi = 0; gi < ALLOC_N; gi++) begin : g_alloc_lane
        logic [TAG_W-1:0] rd_idx;
        assign rd_idx = rd_ptr_q[TAG_W-1:0] + alloc_pre[gi*TAG_W +: TAG_W];
        assign alloc_tag[gi*TAG_W +: TAG_W] = alloc_req[gi] ? mem_q[rd_idx] : '0;
    end

    // Port j writes the tail offset by the number of valid ports below it.
    for (genvar gi = 0; gi < REL_N; gi++) begin : g_rel_port
        assign rel_idx[gi] = wr_ptr_q[TAG_W-1:0] + rel_pre[gi*TAG_W +: TAG_W];
    end

    // Next pointer values; flush is handled in the register block.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (grant) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(na);
        end
        if (rel_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(nr);
        end
    end

    // Pointer registers: reset and flush both give an empty-consumed, full-free list.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= PTR_W'(DEPTH);
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= PTR_W'(DEPTH);
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Tag array: identity image on reset/flush, compacted writes on release.
    // Release slots lie outside the allocation window, so reads never alias writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= TAG_W'(k);
            end
        end else if (flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= TAG_W'(k);
            end
        end else if (rel_accept) begin
            for (int j = 0; j < REL_N; j++) begin
                if (rel_en[j]) begin
                    mem_q[rel_idx[j]] <= rel_tag[j*TAG_W +: TAG_W];
                end
            end
        end
    end

    // Sticky overflow flag; only reset clears it, flush leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_err_q <= 1'b0;
        end else if (!flush && ovf_hit) begin
            ovf_err_q <= 1'b1;
        end
    end

    assign alloc_ok = grant;
    assign free_cnt = free_now;
    assign ovf_err  = ovf_err_q;

endmodule : itag_freelist

// File: tb/tb_itag_freelist.sv
// Directed bench for the instruction-tag free list.
module tb_itag_freelist;

    localparam int TAG_W   = 5;
    localparam int ALLOC_N = 4;
    localparam int REL_N   = 8;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     flush;
    logic [ALLOC_N-1:0]       alloc_req;
    logic                     alloc_ok;
    logic [ALLOC_N*TAG_W-1:0] alloc_tag;
    logic [REL_N-1:0]         rel_en;
    logic [REL_N*TAG_W-1:0]   rel_tag;
    logic [TAG_W:0]           free_cnt;
    logic                     ovf_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    itag_freelist #(
        .TAG_W   (TAG_W),
        .ALLOC_N (ALLOC_N),
        .REL_N   (REL_N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .alloc_req (alloc_req),
        .alloc_ok  (alloc_ok),
        .alloc_tag (alloc_tag),
        .rel_en    (rel_en),
        .rel_tag   (rel_tag),
        .free_cnt  (free_cnt),
        .ovf_err   (ovf_err)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush     = 1'b0;
        alloc_req = '0;
        rel_en    = '0;
        rel_tag   = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic alloc_groups(input int groups);
        for (int g = 0; g < groups; g++) begin
            alloc_req = 4'hF;
            cycle();
        end
        alloc_req = '0;
        #1;
    endtask

    task automatic test_reset();
        int exp_t[4];
        $display("[TB] test_reset");
        do_reset();
        tests++;
        if (free_cnt !== 6'd32) begin
            fails++; $display("FAIL reset_free_cnt got %0d exp 32", free_cnt);
        end
        tests++;
        if (ovf_err !== 1'b0) begin
            fails++; $display("FAIL reset_ovf got %0b exp 0", ovf_err);
        end
        tests++;
        if (alloc_ok !== 1'b0) begin
            fails++; $display("FAIL reset_idle_ok got %0b exp 0", alloc_ok);
        end
        alloc_req = 4'b1111;
        #1;
        exp_t = '{0, 1, 2, 3};
        tests++;
        if (alloc_ok !== 1'b1) begin
            fails++; $display("FAIL full_group_ok got %0b exp 1", alloc_ok);
        end
        for (int i = 0; i < ALLOC_N; i++) begin
            tests++;
            if (alloc_tag[i*TAG_W +: TAG_W] !== TAG_W'(exp_t[i])) begin
                fails++;
                $display("FAIL full_group_tag lane %0d got %0d exp %0d", i, alloc_tag[i*TAG_W +: TAG_W], exp_t[i]);
            end
        end
        cycle();
        alloc_req = '0;
        #1;
        tests++;
        if (free_cnt !== 6'd28) begin
            fails++; $display("FAIL full_group_free got %0d exp 28", free_cnt);
        end
    endtask

    task automatic test_sparse_lanes();
        int exp_t[4];
        $display("[TB] test_sparse_lanes");
        do_reset();
        alloc_req = 4'b1010;
        #1;
        exp_t = '{0, 0, 0, 1};
        tests++;
        if (alloc_ok !== 1'b1) begin
            fails++; $display("FAIL sparse_ok got %0b exp 1", alloc_ok);
        end
        for (int i = 0; i < ALLOC_N; i++) begin
            tests++;
            if (alloc_tag[i*TAG_W +: TAG_W] !== TAG_W'(exp_t[i])) begin
                fails++;
                $display("FAIL sparse_tag lane %0d got %0d exp %0d", i, alloc_tag[i*TAG_W +: TAG_W], exp_t[i]);
            end
        end
        cycle();
        alloc_req = '0;
        #1;
        tests++;
        if (free_cnt !== 6'd30) begin
            fails++; $display("FAIL sparse_free got %0d exp 30", free_cnt);
        end
    endtask

    // Continues from test_sparse_lanes: head at entry 2, 30 free.
    task automatic test_stall_and_release();
        int exp_t[4];
        $display("[TB] test_stall_and_release");
        alloc_groups(7);
        tests++;
        if (free_cnt !== 6'd2) begin
            fails++; $display("FAIL stall_pre_free got %0d exp 2", free_cnt);
        end
        alloc_req = 4'b0111;
        #1;
        tests++;
        if (alloc_ok !== 1'b0) begin
            fails++; $display("FAIL stall_ok got %0b exp 0", alloc_ok);
        end
        cycle();
        tests++;
        if (free_cnt !== 6'd2) begin
            fails++; $display("FAIL stall_free_held got %0d exp 2", free_cnt);
        end
        alloc_req = '0;
        rel_en    = 8'h03;
        rel_tag   = '0;
        rel_tag[0*TAG_W +: TAG_W] = 5'd9;
        rel_tag[1*TAG_W +: TAG_W] = 5'd4;
        cycle();
        idle_inputs();
        #1;
        tests++;
        if (free_cnt !== 6'd4) begin
            fails++; $display("FAIL release_free got %0d exp 4", free_cnt);
        end
        alloc_req = 4'b0111;
        #1;
        exp_t = '{30, 31, 9, 0};
        tests++;
        if (alloc_ok !== 1'b1) begin
            fails++; $display("FAIL after_release_ok got %0b exp 1", alloc_ok);
        end
        for (int i = 0; i < ALLOC_N; i++) begin
            tests++;
            if (alloc_tag[i*TAG_W +: TAG_W] !== TAG_W'(exp_t[i])) begin
                fails++;
                $display("FAIL after_release_tag lane %0d got %0d exp %0d", i, alloc_tag[i*TAG_W +: TAG_W], exp_t[i]);
            end
        end
        cycle();
        alloc_req = '0;
        #1;
        tests++;
        if (free_cnt !== 6'd1) begin
            fails++; $display("FAIL after_release_free got %0d exp 1", free_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int exp_t[4];
        $display("[TB] test_back_to_back");
        do_reset();
        alloc_groups(7);
        alloc_req = 4'b0001;
        cycle();
        alloc_req = '0;
        #1;
        tests++;
        if (free_cnt !== 6'd3) begin
            fails++; $display("FAIL b2b_pre_free got %0d exp 3", free_cnt);
        end
        alloc_req = 4'b0011;
        rel_en    = 8'h01;
        rel_tag   = '0;
        rel_tag[0*TAG_W +: TAG_W] = 5'd7;
        #1;
        exp_t = '{29, 30, 0, 0};
        tests++;
        if (alloc_ok !== 1'b1) begin
            fails++; $display("FAIL b2b_ok got %0b exp 1", alloc_ok);
        end
        for (int i = 0; i < ALLOC_N; i++) begin
            tests++;
            if (alloc_tag[i*TAG_W +: TAG_W] !== TAG_W'(exp_t[i])) begin
                fails++;
                $display("FAIL b2b_tag lane %0d got %0d exp %0d", i, alloc_tag[i*TAG_W +: TAG_W], exp_t[i]);
            end
        end
        cycle();
        idle_inputs();
        #1;
        tests++;
        if (free_cnt !== 6'd2) begin
            fails++; $display("FAIL b2b_free got %0d exp 2", free_cnt);
        end
        alloc_req = 4'b0011;
        #1;
        exp_t = '{31, 7, 0, 0};
        for (int i = 0; i < ALLOC_N; i++) begin
            tests++;
            if (alloc_tag[i*TAG_W +: TAG_W] !== TAG_W'(exp_t[i])) begin
                fails++;
                $display("FAIL b2b_order_tag lane %0d got %0d exp %0d", i, alloc_tag[i*TAG_W +: TAG_W], exp_t[i]);
            end
        end
        cycle();
        alloc_req = 4'b0001;
        #1;
        tests++;
        if (free_cnt !== 6'd0) begin
            fails++; $display("FAIL empty_free got %0d exp 0", free_cnt);
        end
        tests++;
        if (alloc_ok !== 1'b0) begin
            fails++; $display("FAIL empty_ok got %0b exp 0", alloc_ok);
        end
        alloc_req = '0;
    endtask

    task automatic test_flush();
        $display("[TB] test_flush");
        do_reset();
        alloc_groups(5);
        tests++;
        if (free_cnt !== 6'd12) begin
            fails++; $display("FAIL flush_pre_free got %0d exp 12", free_cnt);
        end
        flush     = 1'b1;
        alloc_req = 4'hF;
        rel_en    = 8'hFF;
        for (int j = 0; j < REL_N; j++) rel_tag[j*TAG_W +: TAG_W] = 5'd3;
        #1;
        tests++;
        if (alloc_ok !== 1'b0) begin
            fails++; $display("FAIL flush_ok got %0b exp 0", alloc_ok);
        end
        cycle();
        idle_inputs();
        alloc_req = 4'hF;
        #1;
        tests++;
        if (free_cnt !== 6'd32) begin
            fails++; $display("FAIL flush_free got %0d exp 32", free_cnt);
        end
        tests++;
        if (ovf_err !== 1'b0) begin
            fails++; $display("FAIL flush_ovf got %0b exp 0", ovf_err);
        end
        for (int i = 0; i < ALLOC_N; i++) begin
            tests++;
            if (alloc_tag[i*TAG_W +: TAG_W] !== TAG_W'(i)) begin
                fails++;
                $display("FAIL flush_tag lane %0d got %0d exp %0d", i, alloc_tag[i*TAG_W +: TAG_W], i);
            end
        end
        alloc_req = '0;
    endtask

    task automatic test_overflow();
        $display("[TB] test_overflow");
        do_reset();
        rel_en  = 8'h01;
        rel_tag = '0;
        rel_tag[0*TAG_W +: TAG_W] = 5'd5;
        cycle();
        idle_inputs();
        #1;
        tests++;
        if (ovf_err !== 1'b1) begin
            fails++; $display("FAIL ovf_set got %0b exp 1", ovf_err);
        end
        tests++;
        if (free_cnt !== 6'd32) begin
            fails++; $display("FAIL ovf_free got %0d exp 32", free_cnt);
        end
        cycle();
        tests++;
        if (ovf_err !== 1'b1) begin
            fails++; $display("FAIL ovf_sticky got %0b exp 1", ovf_err);
        end
        alloc_req = 4'hF;
        #1;
        for (int i = 0; i < ALLOC_N; i++) begin
            tests++;
            if (alloc_tag[i*TAG_W +: TAG_W] !== TAG_W'(i)) begin
                fails++;
                $display("FAIL ovf_dropped_tag lane %0d got %0d exp %0d", i, alloc_tag[i*TAG_W +: TAG_W], i);
            end
        end
        cycle();
        alloc_req = '0;
        #1;
        tests++;
        if (free_cnt !== 6'd28) begin
            fails++; $display("FAIL ovf_alloc_free got %0d exp 28", free_cnt);
        end
        // Reset between clock edges must clear state without waiting for clk.
        rst_n = 1'b0;
        #1;
        tests++;
        if (free_cnt !== 6'd32) begin
            fails++; $display("FAIL async_rst_free got %0d exp 32", free_cnt);
        end
        tests++;
        if (ovf_err !== 1'b0) begin
            fails++; $display("FAIL async_rst_ovf got %0b exp 0", ovf_err);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_wrap();
        int q[$];
        int got[4];
        $display("[TB] test_wrap");
        do_reset();
        for (int t = 0; t < 32; t++) q.push_back(t);
        for (int r = 0; r < 40; r++) begin
            alloc_req = 4'hF;
            #1;
            tests++;
            if (alloc_ok !== 1'b1) begin
                fails++; $display("FAIL wrap_ok round %0d got %0b exp 1", r, alloc_ok);
            end
            for (int i = 0; i < ALLOC_N; i++) begin
                got[i] = q.pop_front();
                tests++;
                if (alloc_tag[i*TAG_W +: TAG_W] !== TAG_W'(got[i])) begin
                    fails++;
                    $display("FAIL wrap_tag round %0d lane %0d got %0d exp %0d", r, i, alloc_tag[i*TAG_W +: TAG_W], got[i]);
                end
            end
            cycle();
            alloc_req = '0;
            // Return the group in reverse order so the free order gets shuffled.
            rel_en  = 8'h0F;
            rel_tag = '0;
            for (int j = 0; j < 4; j++) begin
                rel_tag[j*TAG_W +: TAG_W] = TAG_W'(got[3-j]);
                q.push_back(got[3-j]);
            end
            cycle();
            idle_inputs();
            #1;
            tests++;
            if (free_cnt !== 6'd32) begin
                fails++; $display("FAIL wrap_free round %0d got %0d exp 32", r, free_cnt);
            end
        end
        tests++;
        if (ovf_err !== 1'b0) begin
            fails++; $display("FAIL wrap_ovf got %0b exp 0", ovf_err);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        idle_inputs();
        #2;
        test_reset();
        test_sparse_lanes();
        test_stall_and_release();
        test_back_to_back();
        test_flush();
        test_overflow();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_itag_freelist
